// File: rtl/id_operand_stage_if.sv
// Handshake, decoded-bundle and writeback signals between the decode/operand stage
// and its neighbours. The slave modport is the stage's own view.
interface id_operand_stage_if #(
  parameter int unsigned DW = 19
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [4:0]    opcode;
  logic [9:0]    immediate;
  logic [2:0]    rd;
  logic          wr_req;
  logic          illegal;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          flush;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data, flush,
    input  in_ready, out_valid, op1, op2, opcode, immediate, rd, wr_req, illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data, flush,
    output in_ready, out_valid, op1, op2, opcode, immediate, rd, wr_req, illegal
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode + operand fetch ahead of the 19-bit ALU: 8x19 register file, RAW/WAW scoreboard.
// Optional macro WB_BYPASS_EN forwards wb_data to a source retiring in the same cycle.
module id_operand_stage #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 19
) (
  input logic               clk,
  input logic               rst_n,
  id_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_ILL} cls_e;

  logic [DW-1:0]    r_rf [NREGS];
  logic [NREGS-1:0] r_pend;
  logic             r_out_valid;
  logic [DW-1:0]    r_op1;
  logic [DW-1:0]    r_op2;
  logic [4:0]       r_opcode;
  logic [9:0]       r_imm;
  logic [2:0]       r_rd;
  logic             r_wr_req;
  logic             r_illegal;

  cls_e             w_cls;
  logic [4:0]       w_opc;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs1;
  logic [2:0]       w_rs2;
  logic             w_unary;
  logic             w_use_rs1;
  logic             w_use_rs2;
  logic             w_wr_req;
  logic [NREGS-1:0] w_pend_src;
  logic [DW-1:0]    w_src1;
  logic [DW-1:0]    w_src2;
  logic             w_haz;
  logic             w_in_ready;
  logic             w_accept;
  logic [DW-1:0]    w_op1;
  logic [DW-1:0]    w_op2;
  logic [9:0]       w_imm;
  logic [NREGS-1:0] w_pend_next;
  logic             w_unused_bit0;

  assign w_unused_bit0 = bus.in_instr[0];

  always_comb begin
    w_opc = bus.in_instr[18:14];
    w_rd  = bus.in_instr[13:11];
    if (!w_opc[4])                w_cls = CLS_R;
    else if (w_opc[3:2] == 2'b00) w_cls = CLS_I;
    else                          w_cls = CLS_ILL;
    w_rs1 = (w_cls == CLS_I) ? w_rd : bus.in_instr[10:8];
    w_rs2 = bus.in_instr[7:5];
    case (w_opc)
      5'b00111, 5'b01001, 5'b01010, 5'b01100, 5'b01101: w_unary = 1'b1;
      default:                                          w_unary = 1'b0;
    endcase
    w_use_rs1 = (w_cls != CLS_ILL);
    w_use_rs2 = (w_cls == CLS_R) && !w_unary;
    w_wr_req  = (w_cls != CLS_ILL);
  end

`ifdef WB_BYPASS_EN
  // A source retiring this cycle is no longer a hazard; its value comes from wb_data.
  always_comb begin
    w_pend_src = r_pend;
    if (bus.wb_en) w_pend_src[bus.wb_addr] = 1'b0;
    w_src1 = (bus.wb_en && bus.wb_addr == w_rs1) ? bus.wb_data : r_rf[w_rs1];
    w_src2 = (bus.wb_en && bus.wb_addr == w_rs2) ? bus.wb_data : r_rf[w_rs2];
  end
`else
  always_comb begin
    w_pend_src = r_pend;
    w_src1     = r_rf[w_rs1];
    w_src2     = r_rf[w_rs2];
  end
`endif

  always_comb begin
    // WAW check uses the registered scoreboard even when bypassing sources.
    w_haz = (w_use_rs1 && w_pend_src[w_rs1]) ||
            (w_use_rs2 && w_pend_src[w_rs2]) ||
            (w_wr_req  && r_pend[w_rd]);
    w_in_ready = (!r_out_valid || bus.out_ready) && !w_haz && !bus.flush;
    w_accept   = bus.in_valid && w_in_ready;
    w_op1      = w_use_rs1 ? w_src1 : '0;
    w_op2      = w_use_rs2 ? w_src2 : '0;
    w_imm      = (w_cls == CLS_I) ? bus.in_instr[10:1] : '0;
  end

  // Set on accept is applied last so it overrides a same-index writeback clear.
  always_comb begin
    w_pend_next = r_pend;
    if (bus.wb_en) w_pend_next[bus.wb_addr] = 1'b0;
    if (bus.flush && r_out_valid && r_wr_req) w_pend_next[r_rd] = 1'b0;
    if (w_accept && w_wr_req) w_pend_next[w_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_opcode    <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_wr_req    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (bus.wb_en) r_rf[bus.wb_addr] <= bus.wb_data;
      r_pend <= w_pend_next;
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_opcode    <= w_opc;
        r_imm       <= w_imm;
        r_rd        <= w_rd;
        r_wr_req    <= w_wr_req;
        r_illegal   <= (w_cls == CLS_ILL);
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.op1       = r_op1;
  assign bus.op2       = r_op2;
  assign bus.opcode    = r_opcode;
  assign bus.immediate = r_imm;
  assign bus.rd        = r_rd;
  assign bus.wr_req    = r_wr_req;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed vectors with literal checks plus a per-cycle
// comparison against a behavioural model of decode, scoreboard and register file.
module tb_id_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_operand_stage_if #(.DW(19)) bus ();

  id_operand_stage #(.NREGS(8), .DW(19)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [18:0] op1;
    logic [18:0] op2;
    logic [4:0]  opc;
    logic [9:0]  imm;
    logic [2:0]  rd;
    logic        wr;
    logic        ill;
  } bundle_t;

  typedef struct {
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    bit          ill;
    bit          itype;
    bit          uses1;
    bit          uses2;
    logic [9:0]  imm;
  } dec_t;

  logic [18:0] m_rf [8];
  bit          m_pend [8];
  bit          m_ov;
  bundle_t     m_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic dec_t dec(input logic [18:0] w);
    dec_t d;
    d.op    = int'(w[18:14]);
    d.rd    = int'(w[13:11]);
    d.ill   = (d.op >= 20);
    d.itype = (d.op >= 16) && (d.op <= 19);
    d.rs1   = d.itype ? d.rd : int'(w[10:8]);
    d.rs2   = int'(w[7:5]);
    d.uses1 = !d.ill;
    d.uses2 = (d.op < 16) && !(d.op inside {7, 9, 10, 12, 13});
    d.imm   = d.itype ? w[10:1] : 10'd0;
    return d;
  endfunction

  function automatic bit src_busy(input int r);
`ifdef WB_BYPASS_EN
    if (bus.wb_en && int'(bus.wb_addr) == r) return 1'b0;
`endif
    return m_pend[r];
  endfunction

  function automatic logic [18:0] src_val(input int r);
`ifdef WB_BYPASS_EN
    if (bus.wb_en && int'(bus.wb_addr) == r) return bus.wb_data;
`endif
    return m_rf[r];
  endfunction

  function automatic bit exp_ready();
    dec_t d;
    bit   stall;
    d     = dec(bus.in_instr);
    stall = (d.uses1 && src_busy(d.rs1)) || (d.uses2 && src_busy(d.rs2)) ||
            (!d.ill && m_pend[d.rd]);
    return (!m_ov || bus.out_ready) && !stall && !bus.flush;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_rf[i]   = '0;
        m_pend[i] = 1'b0;
      end
      m_ov = 1'b0;
      m_b  = '0;
    end else begin
      dec_t d;
      bit   acc;
      d   = dec(bus.in_instr);
      acc = bus.in_valid && exp_ready();
      if (bus.flush) begin
        if (m_ov && m_b.wr) m_pend[m_b.rd] = 1'b0;
        m_ov = 1'b0;
      end else if (acc) begin
        m_ov      = 1'b1;
        m_b.op1   = d.uses1 ? src_val(d.rs1) : 19'd0;
        m_b.op2   = d.uses2 ? src_val(d.rs2) : 19'd0;
        m_b.opc   = 5'(d.op);
        m_b.imm   = d.imm;
        m_b.rd    = 3'(d.rd);
        m_b.wr    = !d.ill;
        m_b.ill   = d.ill;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      if (bus.wb_en) begin
        m_rf[bus.wb_addr]   = bus.wb_data;
        m_pend[bus.wb_addr] = 1'b0;
      end
      if (acc && !d.ill) m_pend[d.rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", bus.in_ready, exp_ready());
      chk("m_out_valid", bus.out_valid, m_ov);
      if (m_ov) begin
        chk("m_op1", bus.op1, m_b.op1);
        chk("m_op2", bus.op2, m_b.op2);
        chk("m_opcode", bus.opcode, m_b.opc);
        chk("m_immediate", bus.immediate, m_b.imm);
        chk("m_rd", bus.rd, m_b.rd);
        chk("m_wr_req", bus.wr_req, m_b.wr);
        chk("m_illegal", bus.illegal, m_b.ill);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int a, input int d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'(a);
    bus.wb_data = 19'(d);
    tick();
    bus.wb_en   = 1'b0;
  endtask

  function automatic logic [18:0] rt(input int op, input int rd, input int rs1, input int rs2);
    return {5'(op), 3'(rd), 3'(rs1), 3'(rs2), 5'b00000};
  endfunction

  function automatic logic [18:0] it(input int op, input int rd, input logic [9:0] imm);
    return {5'(op), 3'(rd), imm, 1'b0};
  endfunction

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    repeat (3) tick();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_op1", bus.op1, 0);
    chk("reset_wr_req", bus.wr_req, 0);
    rst_n = 1'b1;
    tick();

    wb(2, 5); wb(3, 7); wb(4, 20);
    tick();

    // ADD r1 = r2 + r3
    bus.in_valid = 1'b1;
    bus.in_instr = rt(0, 1, 2, 3);
    #1 chk("add_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("add_valid", bus.out_valid, 1);
    chk("add_op1", bus.op1, 5);
    chk("add_op2", bus.op2, 7);
    chk("add_opcode", bus.opcode, 0);
    chk("add_rd", bus.rd, 1);
    chk("add_wr_req", bus.wr_req, 1);
    chk("add_imm", bus.immediate, 0);

    // ADDI r4, imm 3FF
    bus.in_valid = 1'b1;
    bus.in_instr = it(16, 4, 10'h3FF);
    tick();
    bus.in_valid = 1'b0;
    chk("addi_op1", bus.op1, 20);
    chk("addi_op2", bus.op2, 0);
    chk("addi_imm", bus.immediate, 10'h3FF);
    chk("addi_opcode", bus.opcode, 5'b10000);

    // SUB r5 = r1 - r2 waits for r1 writeback
    bus.in_valid = 1'b1;
    bus.in_instr = rt(1, 5, 1, 2);
    #1 chk("raw_stall_a", bus.in_ready, 0);
    tick();
    chk("raw_stall_b", bus.in_ready, 0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd1;
    bus.wb_data = 19'd9;
`ifdef WB_BYPASS_EN
    #1 chk("raw_wb_cycle_ready", bus.in_ready, 1);
    tick();
    bus.wb_en = 1'b0;
`else
    #1 chk("raw_wb_cycle_ready", bus.in_ready, 0);
    tick();
    bus.wb_en = 1'b0;
    #1 chk("raw_after_wb_ready", bus.in_ready, 1);
    tick();
`endif
    bus.in_valid = 1'b0;
    chk("raw_op1", bus.op1, 9);
    chk("raw_op2", bus.op2, 5);
    chk("raw_rd", bus.rd, 5);

    // Backpressure
    bus.in_valid = 1'b1;
    bus.in_instr = rt(2, 7, 2, 3);
    tick();
    bus.out_ready = 1'b0;
    bus.in_instr  = rt(3, 0, 2, 3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_opcode", bus.opcode, 2);
      chk("bp_rd", bus.rd, 7);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_opcode", bus.opcode, 3);
    chk("bp_second_rd", bus.rd, 0);

    // Illegal opcode 10101 naming pending r7: no hazard, no scoreboard effect
    bus.in_valid = 1'b1;
    bus.in_instr = {5'b10101, 3'd7, 3'd1, 3'd2, 5'b00000};
    #1 chk("ill_ready", bus.in_ready, 1);
    tick();
    chk("ill_flag", bus.illegal, 1);
    chk("ill_wr_req", bus.wr_req, 0);
    chk("ill_op1", bus.op1, 0);
    chk("ill_op2", bus.op2, 0);
    bus.in_instr = rt(0, 2, 3, 3);
    #1 chk("ill_next_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("ill_next_op1", bus.op1, 7);

    for (int i = 0; i < 8; i++) wb(i, 3 * i + 1);
    tick();

    // Flush a held INC r6
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = rt(12, 6, 3, 0);
    tick();
    chk("inc_op1", bus.op1, 10);
    chk("inc_op2", bus.op2, 0);
    bus.in_instr = rt(0, 1, 6, 7);
    bus.flush    = 1'b1;
    #1 chk("flush_ready", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    #1 chk("post_flush_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("reader_valid", bus.out_valid, 1);
    chk("reader_op1", bus.op1, 19);
    chk("reader_op2", bus.op2, 22);

    // Reset mid-operation drops pending r1
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = rt(0, 1, 2, 3);
    #1 chk("waw_stall", bus.in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("rst_mid_ready", bus.in_ready, 1);
    chk("rst_mid_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("rst_mid_op1", bus.op1, 0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
